// File: rtl/uart_tx_string_seq.sv
// Sends a latched, right-aligned ASCII string one byte at a time to a UART frame
// transmitter over a tx_start/tx_done handshake, with optional CR/LF suffix and abort.
module uart_tx_string_seq #(
  parameter int MAX_CHARS   = 32,
  parameter int LEN_W       = 6,
  parameter int APPEND_CRLF = 0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [MAX_CHARS*8-1:0] string_data,
  input  logic [LEN_W-1:0]       string_len,
  input  logic                   tx_done,
  output logic [7:0]             char,
  output logic                   tx_start,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic [LEN_W-1:0]       sent_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FINISH} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_CHARS);
  localparam logic [LEN_W-1:0] CRLF_N  = LEN_W'(APPEND_CRLF * 2);

  state_t                 state, state_nx;
  logic [MAX_CHARS*8-1:0] buffer;
  logic [LEN_W-1:0]       len, len_nx;
  logic [LEN_W-1:0]       idx, idx_nx, idx_inc;
  logic [LEN_W-1:0]       clamp_len, total;
  logic [LEN_W-1:0]       sent_count_nx;
  logic [7:0]             char_nx;
  logic                   abort_pending, abort_pending_nx;
  logic                   capture;

  // Byte i of the outgoing stream: string bytes from the top index down, then CR, LF.
  function automatic logic [7:0] char_at(input logic [MAX_CHARS*8-1:0] text,
                                         input logic [LEN_W-1:0] n,
                                         input logic [LEN_W-1:0] i);
    logic [7:0] c;
    int         pos;
    pos = (int'(n) - 1 - int'(i)) * 8;
    if (i < n) begin
      c = text[pos +: 8];
    end else if (i == n) begin
      c = 8'h0D;
    end else begin
      c = 8'h0A;
    end
    return c;
  endfunction

  assign clamp_len = (string_len > MAX_LEN) ? MAX_LEN : string_len;
  assign total     = len + CRLF_N;
  assign idx_inc   = idx + 1'b1;

  always_comb begin
    state_nx         = state;
    len_nx           = len;
    idx_nx           = idx;
    abort_pending_nx = abort_pending;
    char_nx          = char;
    sent_count_nx    = sent_count;
    capture          = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          capture          = 1'b1;
          len_nx           = clamp_len;
          idx_nx           = '0;
          sent_count_nx    = '0;
          abort_pending_nx = 1'b0;
          if (clamp_len == '0 && APPEND_CRLF == 0) begin
            state_nx = FINISH;
          end else begin
            state_nx = ISSUE;
            char_nx  = char_at(string_data, clamp_len, '0);
          end
        end
      end
      ISSUE: begin
        state_nx = WAIT;
        if (abort) abort_pending_nx = 1'b1;
      end
      WAIT: begin
        if (tx_done) begin
          sent_count_nx = sent_count + 1'b1;
          idx_nx        = idx_inc;
          // A same-cycle abort still lets the finished byte count before stopping.
          if (abort_pending || abort || idx_inc == total) begin
            state_nx         = FINISH;
            abort_pending_nx = abort_pending | abort;
          end else begin
            state_nx = ISSUE;
            char_nx  = char_at(buffer, len, idx_inc);
          end
        end else if (abort) begin
          abort_pending_nx = 1'b1;
        end
      end
      FINISH: begin
        state_nx         = IDLE;
        abort_pending_nx = 1'b0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      len           <= '0;
      idx           <= '0;
      abort_pending <= 1'b0;
      char          <= '0;
      tx_start      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      sent_count    <= '0;
    end else begin
      state         <= state_nx;
      len           <= len_nx;
      idx           <= idx_nx;
      abort_pending <= abort_pending_nx;
      char          <= char_nx;
      tx_start      <= (state_nx == ISSUE);
      busy          <= (state_nx != IDLE);
      done          <= (state == FINISH) && !abort_pending;
      aborted       <= (state == FINISH) && abort_pending;
      sent_count    <= sent_count_nx;
    end
  end

  // Buffer contents are irrelevant until captured, so it carries no reset.
  always_ff @(posedge clk) begin
    if (capture) buffer <= string_data;
  end

endmodule

// File: tb/tb_uart_tx_string_seq.sv
// Scoreboard bench: two instances (without and with CR/LF) share stimulus; expected byte
// streams and completion records come from a queue-based string model.
module tb_uart_tx_string_seq;

  typedef struct {
    bit ab;
    int cnt;
  } end_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [255:0] string_data = '0;
  logic [5:0]   string_len = '0;

  logic       tx_done_w [2];
  logic [7:0] char_w [2];
  logic       tx_start_w [2];
  logic       busy_w [2];
  logic       done_w [2];
  logic       aborted_w [2];
  logic [5:0] sent_w [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat_cur = 20;
  int last_evt [2];
  int end_exp [2];
  int end_seen [2];
  int rcnt [2];

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  end_t       e0[$];
  end_t       e1[$];

  uart_tx_string_seq #(.MAX_CHARS(32), .LEN_W(6), .APPEND_CRLF(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .string_data(string_data), .string_len(string_len), .tx_done(tx_done_w[0]),
    .char(char_w[0]), .tx_start(tx_start_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .aborted(aborted_w[0]), .sent_count(sent_w[0])
  );

  uart_tx_string_seq #(.MAX_CHARS(32), .LEN_W(6), .APPEND_CRLF(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .string_data(string_data), .string_len(string_len), .tx_done(tx_done_w[1]),
    .char(char_w[1]), .tx_start(tx_start_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .aborted(aborted_w[1]), .sent_count(sent_w[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int q_size(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  function automatic int e_size(input int d);
    return (d == 0) ? e0.size() : e1.size();
  endfunction

  function automatic logic [7:0] pop_byte(input int d);
    if (d == 0) return q0.pop_front();
    return q1.pop_front();
  endfunction

  function automatic end_t pop_end(input int d);
    if (d == 0) return e0.pop_front();
    return e1.pop_front();
  endfunction

  function automatic logic [255:0] rand_text();
    logic [255:0] s;
    for (int i = 0; i < 8; i++) s[i*32 +: 32] = $urandom();
    return s;
  endfunction

  task automatic flush_all();
    q0.delete(); q1.delete(); e0.delete(); e1.delete();
    for (int d = 0; d < 2; d++) begin
      end_exp[d] = 0;
      end_seen[d] = 0;
    end
  endtask

  // Model: the first min(len,32) bytes read back-to-front, then CR/LF; an abort
  // landing during byte k keeps exactly k bytes.
  task automatic pushExpect(input int d, input logic [255:0] s, input int len,
                            input bit crlf, input int k);
    logic [7:0] chars[$];
    end_t e;
    int n;
    n = (len > 32) ? 32 : len;
    for (int j = 0; j < n; j++) chars.push_front(s[j*8 +: 8]);
    if (crlf) begin
      chars.push_back(8'h0D);
      chars.push_back(8'h0A);
    end
    if (k > 0 && k <= chars.size()) begin
      e.ab = 1'b1; e.cnt = k;
    end else begin
      e.ab = 1'b0; e.cnt = chars.size();
    end
    for (int i = 0; i < e.cnt; i++) begin
      if (d == 0) q0.push_back(chars[i]);
      else q1.push_back(chars[i]);
    end
    if (d == 0) e0.push_back(e);
    else e1.push_back(e);
    end_exp[d]++;
  endtask

  // Counts tx_start pulses of dut0 starting at the current negedge; returns on the k-th.
  task automatic waitTxStarts(input int k, input int budget, output bit ok);
    int n;
    int b;
    n = 0;
    b = 0;
    while (n < k && b < budget) begin
      if (tx_start_w[0]) n++;
      if (n < k) begin
        @(negedge clk);
        b++;
      end
    end
    ok = (n == k);
    if (!ok) checkOutput("tx_start_wait_timeout", n, k);
  endtask

  task automatic checkResetOutputs();
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("rst_char_d%0d", d), int'(char_w[d]), 0);
      checkOutput($sformatf("rst_tx_start_d%0d", d), int'(tx_start_w[d]), 0);
      checkOutput($sformatf("rst_busy_d%0d", d), int'(busy_w[d]), 0);
      checkOutput($sformatf("rst_done_d%0d", d), int'(done_w[d]), 0);
      checkOutput($sformatf("rst_aborted_d%0d", d), int'(aborted_w[d]), 0);
      checkOutput($sformatf("rst_sent_count_d%0d", d), int'(sent_w[d]), 0);
    end
  endtask

  task automatic applyStimulus(input logic [255:0] s, input int len, input int lat,
                               input int ab_k, input int ab_d, input bit ab_with_start);
    bit ok;
    int budget;
    lat_cur = lat;
    pushExpect(0, s, len, 1'b0, ab_k);
    pushExpect(1, s, len, 1'b1, ab_k);
    @(negedge clk);
    string_data = s;
    string_len = 6'(len);
    start = 1'b1;
    abort = ab_with_start;
    last_evt[0] = cyc;
    last_evt[1] = cyc;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    string_data = rand_text();
    string_len = 6'($urandom_range(0, 63));
    if (ab_k > 0) begin
      waitTxStarts(ab_k, 40 * (lat + 2) + 20, ok);
      if (ok) begin
        repeat (ab_d) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
      end
    end
    budget = 36 * (lat + 2) + 20;
    while ((end_seen[0] < end_exp[0] || end_seen[1] < end_exp[1]) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      checkOutput("completion_timeout", end_seen[0] + end_seen[1], end_exp[0] + end_exp[1]);
      flush_all();
    end
    @(negedge clk);
  endtask

  // tx_done responder: one pulse lat_cur cycles after each tx_start.
  initial begin
    for (int d = 0; d < 2; d++) begin
      tx_done_w[d] = 1'b0;
      rcnt[d] = 0;
    end
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        tx_done_w[d] = 1'b0;
        if (!reset_n) begin
          rcnt[d] = 0;
        end else begin
          if (rcnt[d] > 0) begin
            rcnt[d]--;
            if (rcnt[d] == 0) begin
              tx_done_w[d] = 1'b1;
              last_evt[d] = cyc;
            end
          end
          if (tx_start_w[d]) rcnt[d] = lat_cur;
        end
      end
    end
  end

  // Monitor: pops the scoreboard on every tx_start and every completion pulse.
  initial begin
    logic [7:0] exp_b;
    end_t e;
    int gap;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        for (int d = 0; d < 2; d++) begin
          if (tx_start_w[d]) begin
            if (q_size(d) == 0) begin
              checkOutput($sformatf("unexpected_tx_start_d%0d", d), 1, 0);
            end else begin
              exp_b = pop_byte(d);
              checkOutput($sformatf("char_d%0d", d), int'(char_w[d]), int'(exp_b));
              checkOutput($sformatf("tx_start_latency_d%0d", d), cyc - last_evt[d], 1);
              checkOutput($sformatf("busy_during_tx_d%0d", d), int'(busy_w[d]), 1);
            end
          end
          if (done_w[d] || aborted_w[d]) begin
            end_seen[d]++;
            if (e_size(d) == 0) begin
              checkOutput($sformatf("unexpected_completion_d%0d", d), 1, 0);
            end else begin
              e = pop_end(d);
              gap = cyc - last_evt[d];
              checkOutput($sformatf("done_d%0d", d), int'(done_w[d]), e.ab ? 0 : 1);
              checkOutput($sformatf("aborted_d%0d", d), int'(aborted_w[d]), e.ab ? 1 : 0);
              checkOutput($sformatf("sent_count_d%0d", d), int'(sent_w[d]), e.cnt);
              checkOutput($sformatf("busy_at_end_d%0d", d), int'(busy_w[d]), 0);
              checkOutput($sformatf("bytes_left_d%0d", d), q_size(d), 0);
              if (e.cnt == 0) checkOutput($sformatf("empty_done_latency_d%0d", d), gap, 2);
              else checkOutput($sformatf("end_latency_ok_d%0d", d), int'(gap == 1 || gap == 2), 1);
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [255:0] s;
    int len, lat, n0, k, dl, cnt_tx;
    bit aws, ok;
    for (int d = 0; d < 2; d++) begin
      last_evt[d] = 0;
      end_exp[d] = 0;
      end_seen[d] = 0;
    end
    repeat (3) @(negedge clk);
    checkResetOutputs();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    s = '0; s[39:0] = "HELLO";
    applyStimulus(s, 5, 20, 0, 0, 1'b0);
    s = '0; s[15:0] = "OK";
    applyStimulus(s, 2, 3, 0, 0, 1'b0);
    applyStimulus(rand_text(), 0, 4, 0, 0, 1'b0);
    applyStimulus(rand_text(), 40, 2, 0, 0, 1'b0);
    s = '0; s[79:0] = "ABCDEFGHIJ";
    applyStimulus(s, 10, 20, 2, 3, 1'b0);

    for (int t = 0; t < 12; t++) begin
      len = $urandom_range(0, 40);
      lat = $urandom_range(1, 6);
      n0 = (len > 32) ? 32 : len;
      k = 0;
      dl = 0;
      if (n0 > 0 && $urandom_range(0, 2) == 0) begin
        k = $urandom_range(1, n0);
        dl = $urandom_range(0, lat);
      end
      aws = (k == 0) && ($urandom_range(0, 3) == 0);
      applyStimulus(rand_text(), len, lat, k, dl, aws);
    end

    // Ignored start while busy, then reset in the middle of the third byte.
    s = '0; s[79:0] = "0123456789";
    lat_cur = 8;
    pushExpect(0, s, 10, 1'b0, 0);
    pushExpect(1, s, 10, 1'b1, 0);
    @(negedge clk);
    string_data = s;
    string_len = 6'd10;
    start = 1'b1;
    last_evt[0] = cyc;
    last_evt[1] = cyc;
    @(negedge clk);
    start = 1'b0;
    waitTxStarts(2, 100, ok);
    @(negedge clk);
    string_data = rand_text();
    string_len = 6'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitTxStarts(1, 100, ok);
    repeat (4) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 checkResetOutputs();
    flush_all();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cnt_tx = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx_start_w[0] || tx_start_w[1]) cnt_tx++;
    end
    checkOutput("no_tx_after_reset", cnt_tx, 0);
    applyStimulus(rand_text(), 7, 3, 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
